// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO, baud divider and frame FSM.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [7:0]                    wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [LVL_W-1:0]   r_level;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_ser_tx;
`ifdef UART_TX_PARITY_EN
  logic               r_par;
`endif

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_bit_end;
  logic [7:0]         w_head;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push    = wvalid && !w_full;
  assign w_bit_end = (r_cnt == CNT_W'(DIV - 1));
  // A new byte is taken either from idle or at the last cycle of a stop bit.
  assign w_pop     = (r_level != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd];

  assign wready = !w_full;
  assign ser_tx = r_ser_tx;
  assign busy   = (r_state != S_IDLE) || (r_level != '0);
  assign level  = r_level;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_ser_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      r_cnt <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_cnt + 1'b1;

      if (w_pop) begin
        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
        r_par    <= ^w_head;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state  <= S_START;
            r_ser_tx <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_bit    <= '0;
            r_ser_tx <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state  <= S_PARITY;
              r_ser_tx <= r_par;
`else
              r_state  <= S_STOP;
              r_ser_tx <= 1'b1;
`endif
            end else begin
              r_bit    <= r_bit + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_ser_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state  <= S_STOP;
            r_ser_tx <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_state  <= S_START;
              r_ser_tx <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_ser_tx <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ser_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table of single frames, hand sequences for
// back-to-back, full FIFO and mid-frame reset, then random traffic vs a model.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 3_000_000;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clock  = 1'b0;
  logic       resetb = 1'b0;
  logic [7:0] wdata  = 8'h00;
  logic       wvalid = 1'b0;
  logic       wready;
  logic       ser_tx;
  logic       busy;
  logic [4:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_fifo #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock (clock),
    .resetb(resetb),
    .wdata (wdata),
    .wvalid(wvalid),
    .wready(wready),
    .ser_tx(ser_tx),
    .busy  (busy),
    .level (level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected line value for frame bit k (0 = start bit).
  function automatic logic fbit(input logic [7:0] d, input logic par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return par;
`endif
    return 1'b1;
  endfunction

  // Called just after the edge where the start bit begins.
  task automatic check_frame(input logic [7:0] d, input logic par, input string nm);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("%s bit%0d first", nm, k), ser_tx, fbit(d, par, k));
      repeat (DIV - 1) tick();
      check($sformatf("%s bit%0d last", nm, k), ser_tx, fbit(d, par, k));
      if (k == NB - 1) check($sformatf("%s busy in stop", nm), busy, 1);
      tick();
    end
  endtask

  task automatic single(input vec_t v, input string nm);
    wdata  = v.d;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wdata  = ~v.d;
    check({nm, " line before fall"}, ser_tx, 1);
    check({nm, " level after push"}, level, 1);
    check({nm, " busy after push"}, busy, 1);
    tick();
    check({nm, " level after pop"}, level, 0);
    check_frame(v.d, v.par, nm);
    check({nm, " busy after frame"}, busy, 0);
    check({nm, " line idle after frame"}, ser_tx, 1);
  endtask

  logic [7:0] fb[17];
  logic [7:0] q[$];
  logic [7:0] cur;
  int         e, next_free, start, lows;
  logic       m_push, m_pop, exp_line;

  initial begin
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b0};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'h07, 1'b1};
    vecs[6] = '{8'h80, 1'b1};

    // Reset state
    resetb = 1'b0;
    repeat (3) tick();
    check("reset ser_tx", ser_tx, 1);
    check("reset level", level, 0);
    check("reset busy", busy, 0);
    check("reset wready", wready, 1);
    resetb = 1'b1;
    tick();

    foreach (vecs[i]) single(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back A5 3C FF
    wdata  = 8'hA5;
    wvalid = 1'b1;
    tick();
    wdata = 8'h3C;
    tick();
    wdata = 8'hFF;
    check("b2b level at first start", level, 1);
    fork
      begin
        tick();
        wvalid = 1'b0;
      end
      check_frame(8'hA5, vecs[1].par, "b2b A5");
    join
    check_frame(8'h3C, vecs[2].par, "b2b 3C");
    check_frame(8'hFF, vecs[3].par, "b2b FF");
    check("b2b busy after three frames", busy, 0);

    // Fill to full while the first frame is in flight, then push-while-full at a pop
    for (int k = 0; k < 17; k++) fb[k] = 8'(k * 37 + 5);
    wdata  = fb[0];
    wvalid = 1'b1;
    tick();
    fork
      begin
        for (int k = 1; k < 17; k++) begin
          wdata = fb[k];
          tick();
        end
        check("fill level full", level, 16);
        check("fill wready low", wready, 0);
        wdata = 8'h99;
        repeat (20) tick();
        check("fill level held while refused", level, 16);
      end
      begin
        tick();
        check_frame(fb[0], ^fb[0], "fill0");
      end
    join
    wvalid = 1'b0;
    check("full push+pop level", level, 15);
    check("full push+pop wready", wready, 1);
    for (int k = 1; k < 17; k++) check_frame(fb[k], ^fb[k], $sformatf("fill%0d", k));
    check("fill drained busy", busy, 0);
    check("fill drained line", ser_tx, 1);

    // Mid-frame asynchronous reset with bytes queued
    wdata  = 8'h0F;
    wvalid = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      wdata = 8'hE0 + 8'(k);
      tick();
    end
    wvalid = 1'b0;
    check("rst queued level", level, 4);
    repeat (5 * DIV + DIV / 2 - 3) tick();
    check("rst line low before reset", ser_tx, 0);
    #2;
    resetb = 1'b0;
    #1;
    check("rst async line high", ser_tx, 1);
    check("rst async level", level, 0);
    check("rst async busy", busy, 0);
    check("rst async wready", wready, 1);
    repeat (2) tick();
    resetb = 1'b1;
    lows = 0;
    repeat (2 * FRAME) begin
      tick();
      if (ser_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("rst no output after release", lows, 0);
    single(vecs[0], "post-reset");

    // Random traffic against a timing model of the transmitter
    e = 0;
    next_free = 0;
    start = 0;
    cur = 8'h00;
    for (int i = 0; i < 6000; i++) begin
      if (i < 1200)      wvalid = ($urandom_range(3) == 0);
      else if (i < 2600) wvalid = ($urandom_range(199) == 0);
      else               wvalid = 1'b0;
      wdata = 8'($urandom);
      e++;
      m_push = wvalid && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && (e >= next_free);
      if (m_pop) begin
        cur = q.pop_front();
        start = e;
        next_free = e + FRAME;
      end
      if (m_push) q.push_back(wdata);
      tick();
      exp_line = (e < next_free) ? fbit(cur, ^cur, (e - start) / DIV) : 1'b1;
      check($sformatf("rand ser_tx c%0d", i), ser_tx, exp_line);
      check($sformatf("rand level c%0d", i), level, q.size());
      check($sformatf("rand wready c%0d", i), wready, q.size() != DEPTH);
      check($sformatf("rand busy c%0d", i), busy, (e < next_free) || (q.size() != 0));
    end
    wvalid = 1'b0;
    check("rand final busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
